shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_pkg.sv | 26 ++
 rtl/shift_arbiter_core.sv | 51 +++++
 rtl/shift_arbiter.sv | 162 ++++++++++++++++
 tb/tb_shift_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shift_arbiter_pkg
// Shared constants for the two-requester shift arbiter:
//   - shift operation encodings (SLL, SRA, SRL, reserved)
//   - arbiter FSM state encodings (IDLE, EXEC, RESP)
//   - datapath widths
// -----------------------------------------------------------------------------
package shift_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_SRL  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/shift_arbiter_core.sv
// -----------------------------------------------------------------------------
// shift_core
// Purely combinational 32-bit log shifter, five stages (16/8/4/2/1).
// Ports:
//   data_in  [31:0]  operand
//   amt      [4:0]   shift amount 0..31
//   op               SLL / SRA / SRL / reserved
//   data_out [31:0]  result; the reserved op passes the operand through
// -----------------------------------------------------------------------------
module shift_core
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  amt,
    input  shift_op_e         op,
    output logic [DATA_W-1:0] data_out
);

    logic              shift_left;
    logic [DATA_W-1:0] fill;
    logic [DATA_W-1:0] s16;
    logic [DATA_W-1:0] s8;
    logic [DATA_W-1:0] s4;
    logic [DATA_W-1:0] s2;
    logic [DATA_W-1:0] s1;

    // Right shifts take their vacated bits from 'fill': copies of bit 31
    // for SRA, zeros for SRL. Left shifts always zero-fill.
    always_comb begin
        shift_left = (op == OP_SLL);
        fill       = (op == OP_SRA) ? {DATA_W{data_in[DATA_W-1]}} : '0;

        s16 = data_in;
        if (amt[4]) s16 = shift_left ? {data_in[15:0], 16'b0} : {fill[15:0], data_in[31:16]};

        s8 = s16;
        if (amt[3]) s8 = shift_left ? {s16[23:0], 8'b0} : {fill[7:0], s16[31:8]};

        s4 = s8;
        if (amt[2]) s4 = shift_left ? {s8[27:0], 4'b0} : {fill[3:0], s8[31:4]};

        s2 = s4;
        if (amt[1]) s2 = shift_left ? {s4[29:0], 2'b0} : {fill[1:0], s4[31:2]};

        s1 = s2;
        if (amt[0]) s1 = shift_left ? {s2[30:0], 1'b0} : {fill[0], s2[31:1]};

        data_out = (op == OP_RSVD) ? data_in : s1;
    end

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Two requesters share one shifter. A round-robin arbiter grants one request
// in IDLE, the shift is computed and registered in EXEC, and the result is
// held in RESP until the granted requester takes it.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both 1; a response transfers on a rising edge where
// rspN_valid and rspN_ready are both 1. valid, once raised, is held with
// stable payload until the transfer. ready may be raised at any time and
// carries no meaning while the matching valid is low.
//
// Ports:
//   clock, reset_n              clock, synchronous active-low reset
//   reqN_valid/in/amt/op        request channel N (N = 0,1)
//   reqN_ready                  request N accepted this cycle (IDLE only)
//   rspN_valid, rspN_ready      response channel N
//   rsp_data, rsp_err           shared result payload; err = reserved op used
//   busy                        FSM is not IDLE
//   dbg_state                   current FSM state
// -----------------------------------------------------------------------------
module shift_arbiter
    import shift_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req0_in,
    input  logic [DATA_W-1:0] req1_in,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic [1:0]        req0_op,
    input  logic [1:0]        req1_op,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic              busy,
    output arb_state_e        dbg_state
);

    arb_state_e        state_q,    state_d;
    logic              ptr_q,      ptr_d;      // requester favoured on a tie
    logic              grant_q,    grant_d;    // requester being served
    logic [DATA_W-1:0] opnd_q,     opnd_d;
    logic [AMT_W-1:0]  amt_q,      amt_d;
    shift_op_e         op_q,       op_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q,  rsp_err_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic              busy_q,     busy_d;

    logic              pick1;
    logic              rsp_taken;
    logic [DATA_W-1:0] shift_out;

    shift_core u_shift_core (
        .data_in  (opnd_q),
        .amt      (amt_q),
        .op       (op_q),
        .data_out (shift_out)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        opnd_d       = opnd_q;
        amt_d        = amt_q;
        op_d         = op_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        // Requester 1 wins when it is alone, or when both ask and the
        // pointer favours it.
        pick1     = req1_valid && (!req0_valid || ptr_q);
        rsp_taken = grant_q ? rsp1_ready : rsp0_ready;

        unique case (state_q)
            ST_IDLE: begin
                // ready is gated by reset_n so nothing is accepted on an edge
                // that resets the block.
                if (reset_n && (req0_valid || req1_valid)) begin
                    req0_ready = !pick1;
                    req1_ready = pick1;
                    grant_d    = pick1;
                    opnd_d     = pick1 ? req1_in  : req0_in;
                    amt_d      = pick1 ? req1_amt : req0_amt;
                    op_d       = shift_op_e'(pick1 ? req1_op : req0_op);
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d   = shift_out;
                rsp_err_d    = (op_q == OP_RSVD);
                rsp0_valid_d = !grant_q;
                rsp1_valid_d = grant_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                // Only the granted port's ready matters; the other is ignored.
                if (rsp_taken) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    ptr_d        = !grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            grant_q      <= 1'b0;
            opnd_q       <= '0;
            amt_q        <= '0;
            op_q         <= OP_SLL;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            opnd_q       <= opnd_d;
            amt_q        <= amt_d;
            op_q         <= op_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
// Directed bench for shift_arbiter: reset values, each shift op, reserved op,
// round-robin arbitration, response back-pressure and reset during EXEC.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_in, req1_in;
    logic [4:0]  req0_amt, req1_amt;
    logic [1:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp0_ready, rsp1_ready;
    logic        busy;
    arb_state_e  dbg_state;

    int passed = 0;
    int total  = 0;

    shift_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_in    (req0_in),
        .req1_in    (req1_in),
        .req0_amt   (req0_amt),
        .req1_amt   (req1_amt),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp0_ready (rsp0_ready),
        .rsp1_ready (rsp1_ready),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One request on port idx, wait (bounded) for its response, take it.
    task automatic single_op(input bit idx, input logic [31:0] a, input logic [4:0] s,
                             input logic [1:0] o, output bit acc, output int lat,
                             output logic [31:0] data, output logic err, output bit cleared);
        @(negedge clock);
        if (!idx) begin
            req0_in = a; req0_amt = s; req0_op = o; req0_valid = 1'b1;
        end else begin
            req1_in = a; req1_amt = s; req1_op = o; req1_valid = 1'b1;
        end
        #1;
        acc = idx ? req1_ready : req0_ready;
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        #1;
        while (!(idx ? rsp1_valid : rsp0_valid) && lat < 10) begin
            @(negedge clock);
            #1;
            lat++;
        end
        data = rsp_data;
        err  = rsp_err;
        if (!idx) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        cleared = !(idx ? rsp1_valid : rsp0_valid);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    // Both ports request at once (req0: SLL 0x1 by 1, req1: SRA 0xFFFFFFF0 by 2);
    // the losing request is withdrawn after the grant.
    task automatic pair_op(output bit r0, output bit r1, output bit v0, output bit v1,
                           output logic [31:0] data);
        int n;
        @(negedge clock);
        req0_in = 32'h0000_0001; req0_amt = 5'd1; req0_op = 2'b00; req0_valid = 1'b1;
        req1_in = 32'hFFFF_FFF0; req1_amt = 5'd2; req1_op = 2'b01; req1_valid = 1'b1;
        #1;
        r0 = req0_ready;
        r1 = req1_ready;
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        #1;
        while (!rsp0_valid && !rsp1_valid && n < 10) begin
            @(negedge clock);
            #1;
            n++;
        end
        v0   = rsp0_valid;
        v1   = rsp1_valid;
        data = rsp_data;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        total++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
        total++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data); else passed++;
        total++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %0b expected 0", rsp_err); else passed++;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); else passed++;
        total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_req_ready: got %b expected 00", {req0_ready, req1_ready}); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_sra();
        bit acc, clr; int lat; logic [31:0] d; logic e;
        single_op(1'b0, 32'h8000_0000, 5'd4, 2'b01, acc, lat, d, e, clr);
        total++; if (acc !== 1'b1) $display("FAIL sra_accept: got %0b expected 1", acc); else passed++;
        total++; if (lat !== 2) $display("FAIL sra_latency: got %0d expected 2", lat); else passed++;
        total++; if (d !== 32'hF800_0000) $display("FAIL sra_data: got %h expected f8000000", d); else passed++;
        total++; if (e !== 1'b0) $display("FAIL sra_err: got %0b expected 0", e); else passed++;
        total++; if (clr !== 1'b1) $display("FAIL sra_rsp_cleared: got %0b expected 1", clr); else passed++;
    endtask

    task automatic test_srl_sll();
        bit acc, clr; int lat; logic [31:0] d; logic e;
        single_op(1'b1, 32'h8000_0000, 5'd4, 2'b10, acc, lat, d, e, clr);
        total++; if (acc !== 1'b1) $display("FAIL srl1_accept: got %0b expected 1", acc); else passed++;
        total++; if (d !== 32'h0800_0000) $display("FAIL srl1_data: got %h expected 08000000", d); else passed++;
        single_op(1'b1, 32'h0000_0001, 5'd31, 2'b00, acc, lat, d, e, clr);
        total++; if (d !== 32'h8000_0000) $display("FAIL sll1_amt31_data: got %h expected 80000000", d); else passed++;
        total++; if (lat !== 2) $display("FAIL sll1_latency: got %0d expected 2", lat); else passed++;
        single_op(1'b0, 32'hFFFF_FFFF, 5'd16, 2'b00, acc, lat, d, e, clr);
        total++; if (d !== 32'hFFFF_0000) $display("FAIL sll0_amt16_data: got %h expected ffff0000", d); else passed++;
        single_op(1'b0, 32'h8000_0001, 5'd0, 2'b01, acc, lat, d, e, clr);
        total++; if (d !== 32'h8000_0001) $display("FAIL sra_amt0_data: got %h expected 80000001", d); else passed++;
        single_op(1'b0, 32'h8000_0000, 5'd31, 2'b01, acc, lat, d, e, clr);
        total++; if (d !== 32'hFFFF_FFFF) $display("FAIL sra_amt31_data: got %h expected ffffffff", d); else passed++;
        single_op(1'b0, 32'hF000_0000, 5'd31, 2'b10, acc, lat, d, e, clr);
        total++; if (d !== 32'h0000_0001) $display("FAIL srl_amt31_data: got %h expected 00000001", d); else passed++;
    endtask

    task automatic test_rsvd();
        bit acc, clr; int lat; logic [31:0] d; logic e;
        single_op(1'b0, 32'h1234_5678, 5'd7, 2'b11, acc, lat, d, e, clr);
        total++; if (d !== 32'h1234_5678) $display("FAIL rsvd_data: got %h expected 12345678", d); else passed++;
        total++; if (e !== 1'b1) $display("FAIL rsvd_err: got %0b expected 1", e); else passed++;
    endtask

    task automatic test_arbitration();
        bit r0, r1, v0, v1; logic [31:0] d; int n;
        pulse_reset();
        // Both request right after reset: pointer at 0, req0 wins.
        @(negedge clock);
        req0_in = 32'h0000_0001; req0_amt = 5'd1; req0_op = 2'b00; req0_valid = 1'b1;
        req1_in = 32'hFFFF_FFF0; req1_amt = 5'd2; req1_op = 2'b01; req1_valid = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL arb_first_grant: got %b expected 10", {req0_ready, req1_ready}); else passed++;
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        #1;
        total++; if (req1_ready !== 1'b0) $display("FAIL arb_exec_ready: got %0b expected 0", req1_ready); else passed++;
        @(negedge clock);
        #1;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b10) $display("FAIL arb_rsp0_valid: got %b expected 10", {rsp0_valid, rsp1_valid}); else passed++;
        total++; if (rsp_data !== 32'h0000_0002) $display("FAIL arb_rsp0_data: got %h expected 00000002", rsp_data); else passed++;
        // Ready on the non-granted port is ignored.
        rsp1_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        total++; if (rsp0_valid !== 1'b1) $display("FAIL arb_wrong_port_ready: got %0b expected 1", rsp0_valid); else passed++;
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp0_ready = 1'b0;
        #1;
        total++; if (req1_ready !== 1'b1) $display("FAIL arb_second_grant: got %0b expected 1", req1_ready); else passed++;
        @(posedge clock);
        @(negedge clock);
        req1_valid = 1'b0;
        n = 0;
        #1;
        while (!rsp1_valid && n < 10) begin
            @(negedge clock);
            #1;
            n++;
        end
        total++; if (rsp1_valid !== 1'b1) $display("FAIL arb_rsp1_valid: got %0b expected 1", rsp1_valid); else passed++;
        total++; if (rsp_data !== 32'hFFFF_FFFC) $display("FAIL arb_rsp1_data: got %h expected fffffffc", rsp_data); else passed++;
        rsp1_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp1_ready = 1'b0;
        // Third pair: req1 was served last, so req0 wins again.
        pair_op(r0, r1, v0, v1, d);
        total++; if ({r0, r1} !== 2'b10) $display("FAIL arb_third_grant: got %b expected 10", {r0, r1}); else passed++;
        total++; if (d !== 32'h0000_0002) $display("FAIL arb_third_data: got %h expected 00000002", d); else passed++;
    endtask

    task automatic test_round_robin();
        bit r0, r1, v0, v1; logic [31:0] d;
        // req0 was served last: a pair goes to req1, then back to req0.
        pair_op(r0, r1, v0, v1, d);
        total++; if ({r0, r1} !== 2'b01) $display("FAIL rr_grant_a: got %b expected 01", {r0, r1}); else passed++;
        total++; if ({v0, v1} !== 2'b01) $display("FAIL rr_rsp_a: got %b expected 01", {v0, v1}); else passed++;
        total++; if (d !== 32'hFFFF_FFFC) $display("FAIL rr_data_a: got %h expected fffffffc", d); else passed++;
        pair_op(r0, r1, v0, v1, d);
        total++; if ({r0, r1} !== 2'b10) $display("FAIL rr_grant_b: got %b expected 10", {r0, r1}); else passed++;
        total++; if ({v0, v1} !== 2'b10) $display("FAIL rr_rsp_b: got %b expected 10", {v0, v1}); else passed++;
    endtask

    task automatic test_stall();
        int n;
        @(negedge clock);
        req0_in = 32'hA5A5_A5A5; req0_amt = 5'd4; req0_op = 2'b00; req0_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) $display("FAIL stall_accept: got %0b expected 1", req0_ready); else passed++;
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_in = 32'hF000_0000; req1_amt = 5'd28; req1_op = 2'b10; req1_valid = 1'b1;
        @(negedge clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            total++; if (rsp0_valid !== 1'b1) $display("FAIL stall_valid_c%0d: got %0b expected 1", i, rsp0_valid); else passed++;
            total++; if (rsp_data !== 32'h5A5A_5A50) $display("FAIL stall_data_c%0d: got %h expected 5a5a5a50", i, rsp_data); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL stall_busy_c%0d: got %0b expected 1", i, busy); else passed++;
            total++; if (req1_ready !== 1'b0) $display("FAIL stall_req1_ready_c%0d: got %0b expected 0", i, req1_ready); else passed++;
            @(negedge clock);
            #1;
        end
        rsp0_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp0_ready = 1'b0;
        #1;
        total++; if (req1_ready !== 1'b1) $display("FAIL stall_waiting_req1: got %0b expected 1", req1_ready); else passed++;
        @(posedge clock);
        @(negedge clock);
        req1_valid = 1'b0;
        n = 0;
        #1;
        while (!rsp1_valid && n < 10) begin
            @(negedge clock);
            #1;
            n++;
        end
        total++; if (rsp_data !== 32'h0000_000F) $display("FAIL stall_req1_data: got %h expected 0000000f", rsp_data); else passed++;
        rsp1_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_exec();
        bit acc, clr, r0, r1, v0, v1; int lat; logic [31:0] d; logic e;
        // Serve req0 so the pointer favours req1 before the abort.
        single_op(1'b0, 32'h0000_0003, 5'd1, 2'b00, acc, lat, d, e, clr);
        @(negedge clock);
        req1_in = 32'h0000_0003; req1_amt = 5'd2; req1_op = 2'b00; req1_valid = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1) $display("FAIL rexec_accept: got %0b expected 1", req1_ready); else passed++;
        @(posedge clock);
        @(negedge clock);
        req1_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        total++; if (dbg_state !== ST_EXEC) $display("FAIL rexec_in_exec: got %0d expected %0d", dbg_state, ST_EXEC); else passed++;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        total++; if (dbg_state !== ST_IDLE) $display("FAIL rexec_state: got %0d expected %0d", dbg_state, ST_IDLE); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rexec_busy: got %0b expected 0", busy); else passed++;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL rexec_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); else passed++;
        pair_op(r0, r1, v0, v1, d);
        total++; if ({r0, r1} !== 2'b10) $display("FAIL rexec_pair_grant: got %b expected 10", {r0, r1}); else passed++;
        total++; if ({v0, v1} !== 2'b10) $display("FAIL rexec_pair_rsp: got %b expected 10", {v0, v1}); else passed++;
        total++; if (d !== 32'h0000_0002) $display("FAIL rexec_pair_data: got %h expected 00000002", d); else passed++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n    = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_in    = '0;   req1_in    = '0;
        req0_amt   = '0;   req1_amt   = '0;
        req0_op    = '0;   req1_op    = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        test_reset();
        test_sra();
        test_srl_sll();
        test_rsvd();
        test_arbitration();
        test_round_robin();
        test_stall();
        test_reset_exec();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
